// File: rtl/cpu_if.sv
// Word-wide data-memory bus between the CPU datapath and its data memory.
interface cpu_if #(
    parameter int unsigned AW = 12
) ();
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          we;
    logic [31:0]   rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/cpu.sv
// Single-cycle MIPS-I subset CPU with internal Harvard memories.
// One instruction retires per clock; no delay slots, no pipeline.

`ifndef DEF_INST_TYPE
`define DEF_INST_TYPE
`define UNDEF   5'd0
`define ADD     5'd1
`define ADDU    5'd2
`define SUB     5'd3
`define SUBU    5'd4
`define AND     5'd5
`define OR      5'd6
`define XOR     5'd7
`define NOR     5'd8
`define SLT     5'd9
`define SLTU    5'd10
`define SLL     5'd11
`define SRL     5'd12
`define SRA     5'd13
`define JR      5'd14
`define SYSCALL 5'd15
`define ADDI    5'd16
`define ADDIU   5'd17
`define SLTI    5'd18
`define SLTIU   5'd19
`define ANDI    5'd20
`define ORI     5'd21
`define XORI    5'd22
`define LUI     5'd23
`define LW      5'd24
`define SW      5'd25
`define BEQ     5'd26
`define BNE     5'd27
`define J       5'd28
`define JAL     5'd29
`endif

// Instruction memory: read-only from the core, filled by the environment.
module cpu_im #(
    parameter int unsigned AW = 12
) (
    input  logic [AW-1:0] addr_i,
    output logic [31:0]   instr_o
);
    logic [31:0] mem [0:(2**AW)-1];

    assign instr_o = mem[addr_i];
endmodule

// Data memory: combinational read, write on the rising edge.
module cpu_dm #(
    parameter int unsigned AW = 12
) (
    input logic  clk,
    cpu_if.slave bus
);
    logic [31:0] mem [0:(2**AW)-1];

    assign bus.rdata = mem[bus.addr];

    always_ff @(posedge clk) begin
        if (bus.we) mem[bus.addr] <= bus.wdata;
    end
endmodule

// Register file: two combinational read ports, one write port, $0 hardwired.
module cpu_rf (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    input  logic        we_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] register [0:31];

    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : register[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : register[ra2_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) register[i] <= 32'd0;
        end else if (we_i && (wa_i != 5'd0)) begin
            register[wa_i] <= wd_i;
        end
    end
endmodule

// Control unit: classifies the instruction from opcode/funct.
module cpu_cu (
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [4:0] inst_type
);
    always_comb begin
        inst_type = `UNDEF;
        case (opcode_i)
            6'h00: begin
                case (funct_i)
                    6'h20:   inst_type = `ADD;
                    6'h21:   inst_type = `ADDU;
                    6'h22:   inst_type = `SUB;
                    6'h23:   inst_type = `SUBU;
                    6'h24:   inst_type = `AND;
                    6'h25:   inst_type = `OR;
                    6'h26:   inst_type = `XOR;
                    6'h27:   inst_type = `NOR;
                    6'h2A:   inst_type = `SLT;
                    6'h2B:   inst_type = `SLTU;
                    6'h00:   inst_type = `SLL;
                    6'h02:   inst_type = `SRL;
                    6'h03:   inst_type = `SRA;
                    6'h08:   inst_type = `JR;
                    6'h0C:   inst_type = `SYSCALL;
                    default: inst_type = `UNDEF;
                endcase
            end
            6'h08:   inst_type = `ADDI;
            6'h09:   inst_type = `ADDIU;
            6'h0A:   inst_type = `SLTI;
            6'h0B:   inst_type = `SLTIU;
            6'h0C:   inst_type = `ANDI;
            6'h0D:   inst_type = `ORI;
            6'h0E:   inst_type = `XORI;
            6'h0F:   inst_type = `LUI;
            6'h23:   inst_type = `LW;
            6'h2B:   inst_type = `SW;
            6'h04:   inst_type = `BEQ;
            6'h05:   inst_type = `BNE;
            6'h02:   inst_type = `J;
            6'h03:   inst_type = `JAL;
            default: inst_type = `UNDEF;
        endcase
    end
endmodule

module cpu #(
    parameter int unsigned IM_ADDR_BITS = 12,
    parameter int unsigned DM_ADDR_BITS = 12
) (
    input  logic clk,
    input  logic rst,
    output logic overflow
);
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] instr;
    logic [4:0]  inst_type;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] sext;
    logic [31:0] zext;
    logic [31:0] add_rr;
    logic [31:0] sub_rr;
    logic [31:0] add_ri;
    logic        ovf_add;
    logic        ovf_sub;
    logic        ovf_addi;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        dm_we;

    cpu_if #(.AW(DM_ADDR_BITS)) dm_bus ();

    cpu_im #(.AW(IM_ADDR_BITS)) u_IM (
        .addr_i  (pc_q[IM_ADDR_BITS+1:2]),
        .instr_o (instr)
    );

    cpu_dm #(.AW(DM_ADDR_BITS)) u_DM (
        .clk (clk),
        .bus (dm_bus)
    );

    cpu_cu u_CU (
        .opcode_i  (instr[31:26]),
        .funct_i   (instr[5:0]),
        .inst_type (inst_type)
    );

    // A write in the reset cycle is dropped so reset aborts the instruction.
    cpu_rf u_RF (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (rs),
        .ra2_i (rt),
        .wa_i  (wb_addr),
        .wd_i  (wb_data),
        .we_i  (wb_en & ~rst),
        .rd1_o (rs_val),
        .rd2_o (rt_val)
    );

    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign sext  = {{16{instr[15]}}, instr[15:0]};
    assign zext  = {16'd0, instr[15:0]};

    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_plus4 + {sext[29:0], 2'b00};

    assign add_rr = rs_val + rt_val;
    assign sub_rr = rs_val - rt_val;
    assign add_ri = rs_val + sext;

    // Signed overflow: operands agree in sign but the result does not.
    assign ovf_add  = (rs_val[31] == rt_val[31]) && (add_rr[31] != rs_val[31]);
    assign ovf_sub  = (rs_val[31] != rt_val[31]) && (sub_rr[31] != rs_val[31]);
    assign ovf_addi = (rs_val[31] == sext[31])   && (add_ri[31] != rs_val[31]);

    assign dm_bus.addr  = add_ri[DM_ADDR_BITS+1:2];
    assign dm_bus.wdata = rt_val;
    assign dm_bus.we    = dm_we & ~rst;

    always_comb begin
        pc_next  = pc_plus4;
        wb_en    = 1'b0;
        wb_addr  = rd;
        wb_data  = 32'd0;
        dm_we    = 1'b0;
        overflow = 1'b0;
        case (inst_type)
            `ADD: begin
                overflow = ovf_add;
                wb_en    = ~ovf_add;
                wb_data  = add_rr;
            end
            `ADDU: begin wb_en = 1'b1; wb_data = add_rr; end
            `SUB: begin
                overflow = ovf_sub;
                wb_en    = ~ovf_sub;
                wb_data  = sub_rr;
            end
            `SUBU: begin wb_en = 1'b1; wb_data = sub_rr; end
            `AND:  begin wb_en = 1'b1; wb_data = rs_val & rt_val; end
            `OR:   begin wb_en = 1'b1; wb_data = rs_val | rt_val; end
            `XOR:  begin wb_en = 1'b1; wb_data = rs_val ^ rt_val; end
            `NOR:  begin wb_en = 1'b1; wb_data = ~(rs_val | rt_val); end
            `SLT: begin
                wb_en   = 1'b1;
                wb_data = 32'($signed(rs_val) < $signed(rt_val));
            end
            `SLTU: begin wb_en = 1'b1; wb_data = 32'(rs_val < rt_val); end
            `SLL:  begin wb_en = 1'b1; wb_data = rt_val << shamt; end
            `SRL:  begin wb_en = 1'b1; wb_data = rt_val >> shamt; end
            `SRA: begin
                wb_en   = 1'b1;
                wb_data = 32'($signed(rt_val) >>> shamt);
            end
            `JR: pc_next = rs_val;
            `ADDI: begin
                overflow = ovf_addi;
                wb_en    = ~ovf_addi;
                wb_addr  = rt;
                wb_data  = add_ri;
            end
            `ADDIU: begin wb_en = 1'b1; wb_addr = rt; wb_data = add_ri; end
            `SLTI: begin
                wb_en   = 1'b1;
                wb_addr = rt;
                wb_data = 32'($signed(rs_val) < $signed(sext));
            end
            `SLTIU: begin
                wb_en   = 1'b1;
                wb_addr = rt;
                wb_data = 32'(rs_val < sext);
            end
            `ANDI: begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val & zext; end
            `ORI:  begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val | zext; end
            `XORI: begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val ^ zext; end
            `LUI: begin
                wb_en   = 1'b1;
                wb_addr = rt;
                wb_data = {instr[15:0], 16'd0};
            end
            `LW: begin wb_en = 1'b1; wb_addr = rt; wb_data = dm_bus.rdata; end
            `SW: dm_we = 1'b1;
            `BEQ: if (rs_val == rt_val) pc_next = br_target;
            `BNE: if (rs_val != rt_val) pc_next = br_target;
            `J:   pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
            `JAL: begin
                pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
                wb_en   = 1'b1;
                wb_addr = 5'd31;
                wb_data = pc_plus4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= 32'd0;
        else     pc_q <= pc_next;
    end
endmodule

// File: tb/tb_cpu.sv
// Directed bench for the single-cycle cpu: small hand-assembled programs
// with hand-computed architectural results.

`ifndef DEF_INST_TYPE
`define DEF_INST_TYPE
`define SYSCALL 5'd15
`endif

module tb_cpu;
    logic clk = 1'b0;
    logic rst;
    logic overflow;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] prog [0:63];

    always #5 clk = ~clk;

    cpu dut (.clk(clk), .rst(rst), .overflow(overflow));

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(int op, int tgt);
        return {6'(op), 26'(tgt)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    endtask

    // Load the program with reset held for one edge, then release.
    task automatic start_prog();
        rst = 1'b1;
        for (int i = 0; i < 64; i++) dut.u_IM.mem[i] = prog[i];
        step();
        rst = 1'b0;
    endtask

    task automatic run_to(input logic [31:0] target, input string name);
        int n = 0;
        while (dut.pc_q !== target && n < 200) begin
            step();
            n++;
        end
        n_checks++;
        if (dut.pc_q !== target) begin
            n_fail++;
            $display("FAIL %s: pc=%h required %h (cycle budget expired)", name, dut.pc_q, target);
        end
    endtask

    task automatic test_reset();
        clear_prog();
        prog[0] = enc_i(8'h08, 0, 8, 5);
        rst = 1'b1;
        for (int i = 0; i < 64; i++) dut.u_IM.mem[i] = prog[i];
        step();
        n_checks++; if (dut.pc_q !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h required %h", dut.pc_q, 32'd0); end
        n_checks++; if (dut.u_RF.register[8] !== 32'd0) begin n_fail++; $display("FAIL reset_t0: got %h required %h", dut.u_RF.register[8], 32'd0); end
        step();
        n_checks++; if (dut.u_RF.register[8] !== 32'd0) begin n_fail++; $display("FAIL reset_hold_t0: got %h required %h", dut.u_RF.register[8], 32'd0); end
        rst = 1'b0;
        n_checks++; if (dut.pc_next !== 32'd4) begin n_fail++; $display("FAIL first_pc_next: got %h required %h", dut.pc_next, 32'd4); end
        step();
        n_checks++; if (dut.u_RF.register[8] !== 32'd5) begin n_fail++; $display("FAIL first_addi: got %h required %h", dut.u_RF.register[8], 32'd5); end
        n_checks++; if (dut.pc_q !== 32'd4) begin n_fail++; $display("FAIL first_pc: got %h required %h", dut.pc_q, 32'd4); end

        // Reset asserted while a sw is executing must suppress the store.
        clear_prog();
        prog[0] = enc_i(8'h08, 0, 8, 8'h55);
        prog[1] = enc_i(8'h2B, 0, 0, 16);
        prog[2] = enc_i(8'h2B, 0, 8, 16);
        start_prog();
        run_to(32'd8, "abort_reach");
        n_checks++; if (dut.u_DM.mem[4] !== 32'd0) begin n_fail++; $display("FAIL abort_pre: got %h required %h", dut.u_DM.mem[4], 32'd0); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (dut.u_DM.mem[4] !== 32'd0) begin n_fail++; $display("FAIL abort_sw: got %h required %h", dut.u_DM.mem[4], 32'd0); end
        n_checks++; if (dut.pc_q !== 32'd0) begin n_fail++; $display("FAIL abort_pc: got %h required %h", dut.pc_q, 32'd0); end
        run_to(32'd12, "abort_rerun");
        n_checks++; if (dut.u_DM.mem[4] !== 32'h55) begin n_fail++; $display("FAIL rerun_sw: got %h required %h", dut.u_DM.mem[4], 32'h55); end
    endtask

    task automatic test_arith();
        clear_prog();
        prog[0]  = enc_i(8'h0F, 0, 9, 16'h7fff);
        prog[1]  = enc_i(8'h0D, 9, 9, 16'hffff);
        prog[2]  = enc_r(9, 9, 10, 0, 8'h20);
        prog[3]  = enc_r(9, 9, 11, 0, 8'h21);
        prog[4]  = enc_i(8'h08, 0, 12, 3);
        prog[5]  = enc_i(8'h08, 0, 13, 5);
        prog[6]  = enc_r(12, 13, 14, 0, 8'h22);
        prog[7]  = enc_i(8'h08, 0, 15, -1);
        prog[8]  = enc_i(8'h08, 0, 16, 1);
        prog[9]  = enc_r(15, 16, 17, 0, 8'h2A);
        prog[10] = enc_r(15, 16, 18, 0, 8'h2B);
        prog[11] = enc_i(8'h0F, 0, 19, 16'h8000);
        prog[12] = enc_r(0, 19, 20, 4, 8'h03);
        prog[13] = enc_r(0, 19, 21, 4, 8'h02);
        prog[14] = enc_r(0, 0, 22, 0, 8'h27);
        prog[15] = enc_i(8'h08, 9, 23, 1);
        prog[16] = enc_r(19, 16, 24, 0, 8'h22);
        start_prog();
        run_to(32'd8, "arith_add");
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL add_ovf: got %b required %b", overflow, 1'b1); end
        step();
        n_checks++; if (dut.u_RF.register[10] !== 32'd0) begin n_fail++; $display("FAIL add_ovf_nowrite: got %h required %h", dut.u_RF.register[10], 32'd0); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL addu_ovf: got %b required %b", overflow, 1'b0); end
        step();
        n_checks++; if (dut.u_RF.register[11] !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL addu: got %h required %h", dut.u_RF.register[11], 32'hFFFFFFFE); end
        run_to(32'd60, "arith_addi");
        n_checks++; if (dut.u_RF.register[14] !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL sub: got %h required %h", dut.u_RF.register[14], 32'hFFFFFFFE); end
        n_checks++; if (dut.u_RF.register[17] !== 32'd1) begin n_fail++; $display("FAIL slt: got %h required %h", dut.u_RF.register[17], 32'd1); end
        n_checks++; if (dut.u_RF.register[18] !== 32'd0) begin n_fail++; $display("FAIL sltu: got %h required %h", dut.u_RF.register[18], 32'd0); end
        n_checks++; if (dut.u_RF.register[20] !== 32'hF8000000) begin n_fail++; $display("FAIL sra: got %h required %h", dut.u_RF.register[20], 32'hF8000000); end
        n_checks++; if (dut.u_RF.register[21] !== 32'h08000000) begin n_fail++; $display("FAIL srl: got %h required %h", dut.u_RF.register[21], 32'h08000000); end
        n_checks++; if (dut.u_RF.register[22] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL nor: got %h required %h", dut.u_RF.register[22], 32'hFFFFFFFF); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL addi_ovf: got %b required %b", overflow, 1'b1); end
        step();
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sub_ovf: got %b required %b", overflow, 1'b1); end
        n_checks++; if (dut.u_RF.register[23] !== 32'd0) begin n_fail++; $display("FAIL addi_ovf_nowrite: got %h required %h", dut.u_RF.register[23], 32'd0); end
        step();
        n_checks++; if (dut.u_RF.register[24] !== 32'd0) begin n_fail++; $display("FAIL sub_ovf_nowrite: got %h required %h", dut.u_RF.register[24], 32'd0); end
    endtask

    task automatic test_load_store();
        logic [31:0] w;
        clear_prog();
        prog[0] = enc_i(8'h0F, 0, 8, 16'h1234);
        prog[1] = enc_i(8'h0D, 8, 8, 16'h5678);
        prog[2] = enc_i(8'h2B, 0, 8, 8);
        prog[3] = enc_i(8'h23, 0, 9, 8);
        prog[4] = enc_i(8'h0F, 0, 11, 1);
        prog[5] = enc_i(8'h2B, 11, 8, 12);
        start_prog();
        run_to(32'd16, "ls_lw");
        n_checks++; if (dut.u_RF.register[9] !== 32'h12345678) begin n_fail++; $display("FAIL lw: got %h required %h", dut.u_RF.register[9], 32'h12345678); end
        w = dut.u_DM.mem[2];
        n_checks++; if (w !== 32'h12345678) begin n_fail++; $display("FAIL sw_dm2: got %h required %h", w, 32'h12345678); end
        n_checks++; if (w[8 +: 8] !== 8'h56) begin n_fail++; $display("FAIL byte9_lane1: got %h required %h", w[8 +: 8], 8'h56); end
        run_to(32'd24, "ls_wrap");
        n_checks++; if (dut.u_DM.mem[3] !== 32'h12345678) begin n_fail++; $display("FAIL sw_wrap: got %h required %h", dut.u_DM.mem[3], 32'h12345678); end
    endtask

    task automatic test_branch();
        clear_prog();
        prog[0] = enc_i(8'h08, 0, 8, 7);
        prog[1] = enc_i(8'h08, 0, 9, 7);
        prog[2] = enc_i(8'h04, 8, 9, 1);
        prog[3] = enc_i(8'h08, 0, 10, 99);
        prog[4] = enc_i(8'h05, 8, 9, 1);
        prog[5] = enc_i(8'h08, 0, 11, 1);
        prog[6] = enc_i(8'h08, 0, 0, 55);
        prog[7] = enc_i(8'h08, 0, 12, 2);
        start_prog();
        run_to(32'd8, "br_beq");
        n_checks++; if (dut.pc_next !== 32'd16) begin n_fail++; $display("FAIL beq_target: got %h required %h", dut.pc_next, 32'd16); end
        step();
        n_checks++; if (dut.pc_q !== 32'd16) begin n_fail++; $display("FAIL beq_taken: got %h required %h", dut.pc_q, 32'd16); end
        n_checks++; if (dut.pc_next !== 32'd20) begin n_fail++; $display("FAIL bne_not_taken: got %h required %h", dut.pc_next, 32'd20); end
        run_to(32'd32, "br_end");
        n_checks++; if (dut.u_RF.register[10] !== 32'd0) begin n_fail++; $display("FAIL skipped_instr: got %h required %h", dut.u_RF.register[10], 32'd0); end
        n_checks++; if (dut.u_RF.register[11] !== 32'd1) begin n_fail++; $display("FAIL after_bne: got %h required %h", dut.u_RF.register[11], 32'd1); end
        n_checks++; if (dut.u_RF.register[0] !== 32'd0) begin n_fail++; $display("FAIL zero_reg: got %h required %h", dut.u_RF.register[0], 32'd0); end
        n_checks++; if (dut.u_RF.register[12] !== 32'd2) begin n_fail++; $display("FAIL after_zero_write: got %h required %h", dut.u_RF.register[12], 32'd2); end
    endtask

    task automatic test_jump();
        clear_prog();
        prog[0]  = enc_i(8'h08, 0, 2, 0);
        prog[1]  = enc_i(8'h08, 0, 8, 5);
        prog[2]  = enc_j(8'h03, 8);
        prog[3]  = enc_i(8'h08, 0, 9, 1);
        prog[4]  = enc_j(8'h02, 4);
        prog[8]  = enc_r(2, 8, 2, 0, 8'h20);
        prog[9]  = enc_i(8'h08, 8, 8, -1);
        prog[10] = enc_i(8'h05, 8, 0, -3);
        prog[11] = enc_r(31, 0, 0, 0, 8'h08);
        start_prog();
        run_to(32'd32, "jal_reach");
        n_checks++; if (dut.u_RF.register[31] !== 32'd12) begin n_fail++; $display("FAIL jal_ra: got %h required %h", dut.u_RF.register[31], 32'd12); end
        run_to(32'd44, "jr_reach");
        n_checks++; if (dut.pc_next !== 32'd12) begin n_fail++; $display("FAIL jr_target: got %h required %h", dut.pc_next, 32'd12); end
        n_checks++; if (dut.u_RF.register[2] !== 32'd15) begin n_fail++; $display("FAIL loop_sum: got %h required %h", dut.u_RF.register[2], 32'd15); end
        run_to(32'd16, "return_reach");
        n_checks++; if (dut.u_RF.register[9] !== 32'd1) begin n_fail++; $display("FAIL after_return: got %h required %h", dut.u_RF.register[9], 32'd1); end
        n_checks++; if (dut.u_RF.register[8] !== 32'd0) begin n_fail++; $display("FAIL loop_count: got %h required %h", dut.u_RF.register[8], 32'd0); end
        step();
        n_checks++; if (dut.pc_next !== 32'd16) begin n_fail++; $display("FAIL j_self: got %h required %h", dut.pc_next, 32'd16); end
    endtask

    task automatic test_syscall();
        clear_prog();
        prog[0] = enc_i(8'h08, 0, 2, 10);
        prog[1] = 32'h0000000C;
        prog[2] = enc_i(8'h08, 0, 8, 3);
        prog[3] = {6'h3F, 26'h3FFFFFF};
        start_prog();
        run_to(32'd4, "syscall_reach");
        n_checks++; if (dut.u_CU.inst_type !== `SYSCALL) begin n_fail++; $display("FAIL syscall_type: got %h required %h", dut.u_CU.inst_type, `SYSCALL); end
        n_checks++; if (dut.pc_next !== 32'd8) begin n_fail++; $display("FAIL syscall_pc_next: got %h required %h", dut.pc_next, 32'd8); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL syscall_ovf: got %b required %b", overflow, 1'b0); end
        if (dut.u_CU.inst_type === `SYSCALL && dut.u_RF.register[2] === 32'd10)
            $display("syscall: exit requested");
        step();
        n_checks++; if (dut.pc_q !== 32'd8) begin n_fail++; $display("FAIL syscall_pc: got %h required %h", dut.pc_q, 32'd8); end
        n_checks++; if (dut.u_RF.register[2] !== 32'd10) begin n_fail++; $display("FAIL syscall_v0: got %h required %h", dut.u_RF.register[2], 32'd10); end
        run_to(32'd12, "undef_reach");
        n_checks++; if (dut.pc_next !== 32'd16) begin n_fail++; $display("FAIL undef_pc_next: got %h required %h", dut.pc_next, 32'd16); end
        step();
        n_checks++; if (dut.u_RF.register[8] !== 32'd3) begin n_fail++; $display("FAIL undef_t0: got %h required %h", dut.u_RF.register[8], 32'd3); end
        n_checks++; if (dut.u_RF.register[31] !== 32'd0) begin n_fail++; $display("FAIL undef_ra: got %h required %h", dut.u_RF.register[31], 32'd0); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_arith();
        test_load_store();
        test_branch();
        test_jump();
        test_syscall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
